// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM encoding, round constants, S-box and GF(2^8) helpers.
// Also used by the unrolled core, so keep it free of sequencer-specific logic.
package aes_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [3:0] NUM_ROUNDS = 4'd10;
  localparam logic [7:0] RCON_INIT  = 8'h01;
  localparam logic [7:0] XTIME_POLY = 8'h1b;

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction
endpackage

// File: rtl/aes_round_sequencer_if.sv
// Block-in / ciphertext-out handshake bundle plus status for the iterative AES sequencer.
interface aes_round_sequencer_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [127:0] out_key;
  logic         busy;
  logic [3:0]   round_idx;

  modport slave (
    input  in_valid, in_data, in_key, out_ready,
    output in_ready, out_valid, out_data, out_key, busy, round_idx
  );
  modport master (
    output in_valid, in_data, in_key, out_ready,
    input  in_ready, out_valid, out_data, out_key, busy, round_idx
  );
endinterface

// File: rtl/aes_round_comb.sv
// One AES-128 round plus the matching key-schedule step, purely combinational.
// The round uses the freshly expanded key, so state_out and key_out belong to the same round.
module aes_round_comb
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] key,
  input  logic [31:0]  rnum,
  input  logic         last_round,
  output logic [127:0] state_out,
  output logic [127:0] key_out
);
  logic [31:0] t, w0, w1, w2, w3;
  logic [15:0][7:0] sb, sr, mc;

  assign t  = sub_word({key[23:0], key[31:24]}) ^ rnum;
  assign w0 = key[127:96] ^ t;
  assign w1 = key[95:64]  ^ w0;
  assign w2 = key[63:32]  ^ w1;
  assign w3 = key[31:0]   ^ w2;
  assign key_out = {w0, w1, w2, w3};

  // Byte i sits at row i%4, column i/4; ShiftRows pulls from column (c+r)%4.
  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign sb[i] = sbox(state[127-8*i -: 8]);
    assign sr[i] = sb[(i%4) + 4*(((i/4) + (i%4)) % 4)];
    assign state_out[127-8*i -: 8] = (last_round ? sr[i] : mc[i]) ^ key_out[127-8*i -: 8];
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
    assign mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
  end
endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryptor: one shared round datapath reused for 10 cycles per block.
// Holds state, round key, round counter and Rcon; results are latched into separate output regs.
module aes_round_sequencer
  import aes_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  aes_round_sequencer_if.slave  bus
);
  state_e       state_q, state_d;
  logic [127:0] st_q, st_d, rk_q, rk_d;
  logic [127:0] od_q, od_d, ok_q, ok_d;
  logic [3:0]   round_q, round_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [127:0] st_nxt, rk_nxt;
  logic         last_round;

  assign last_round = (round_q == NUM_ROUNDS);

  aes_round_comb u_round (
    .state      (st_q),
    .key        (rk_q),
    .rnum       ({rcon_q, 24'h0}),
    .last_round (last_round),
    .state_out  (st_nxt),
    .key_out    (rk_nxt)
  );

  assign bus.in_ready  = (state_q == IDLE) && rst_n;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.round_idx = round_q;
  assign bus.out_data  = od_q;
  assign bus.out_key   = ok_q;

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    rk_d    = rk_q;
    od_d    = od_q;
    ok_d    = ok_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    case (state_q)
      IDLE: if (bus.in_valid && bus.in_ready) begin
        st_d    = bus.in_data ^ bus.in_key;
        rk_d    = bus.in_key;
        round_d = 4'd1;
        rcon_d  = RCON_INIT;
        state_d = RUN;
      end
      RUN: begin
        st_d   = st_nxt;
        rk_d   = rk_nxt;
        rcon_d = xtime(rcon_q);
        if (last_round) begin
          // Output regs only change here, so they hold across IDLE/RUN of the next block.
          od_d    = st_nxt;
          ok_d    = rk_nxt;
          state_d = DONE;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      DONE: if (bus.out_ready) begin
        round_d = 4'd0;
        rcon_d  = RCON_INIT;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      st_q    <= '0;
      rk_q    <= '0;
      od_q    <= '0;
      ok_q    <= '0;
      round_q <= '0;
      rcon_q  <= RCON_INIT;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rk_q    <= rk_d;
      od_q    <= od_d;
      ok_q    <= ok_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
    end
  end
endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for the iterative AES-128 sequencer using FIPS-197 vectors.
module tb_aes_round_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  aes_round_sequencer_if bus();

  aes_round_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_RK  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_RK   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic [7:0] rc_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [127:0] pt, input logic [127:0] key);
    bus.in_valid = 1'b1;
    bus.in_data  = pt;
    bus.in_key   = key;
  endtask

  // Called just before the accept edge; ends at the first cycle with out_valid high.
  task automatic track(input string tag, input logic [127:0] ct, input logic [127:0] rk,
                       input bit perturb);
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      if (j == 1) bus.in_valid = 1'b0;
      if (perturb) begin
        bus.in_data = {$urandom, $urandom, $urandom, $urandom};
        bus.in_key  = {$urandom, $urandom, $urandom, $urandom};
      end
      chk($sformatf("%s_round%0d", tag, j), {124'h0, bus.round_idx}, 128'(j));
      chk($sformatf("%s_rcon%0d", tag, j), {120'h0, dut.rcon_q}, {120'h0, rc_tab[j-1]});
      chk($sformatf("%s_ov%0d", tag, j), {127'h0, bus.out_valid}, 128'h0);
      chk($sformatf("%s_ir%0d", tag, j), {127'h0, bus.in_ready}, 128'h0);
    end
    @(negedge clk);
    chk({tag, "_ov_done"}, {127'h0, bus.out_valid}, 128'h1);
    chk({tag, "_busy_done"}, {127'h0, bus.busy}, 128'h1);
    chk({tag, "_round_done"}, {124'h0, bus.round_idx}, 128'd10);
    chk({tag, "_data"}, bus.out_data, ct);
    chk({tag, "_key"}, bus.out_key, rk);
  endtask

  task automatic idle_chk(input string tag, input logic [127:0] ct);
    @(negedge clk);
    chk({tag, "_idle_ov"}, {127'h0, bus.out_valid}, 128'h0);
    chk({tag, "_idle_ir"}, {127'h0, bus.in_ready}, 128'h1);
    chk({tag, "_idle_busy"}, {127'h0, bus.busy}, 128'h0);
    chk({tag, "_idle_round"}, {124'h0, bus.round_idx}, 128'h0);
    chk({tag, "_idle_rcon"}, {120'h0, dut.rcon_q}, 128'h01);
    chk({tag, "_idle_hold"}, bus.out_data, ct);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_key    = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ir", {127'h0, bus.in_ready}, 128'h0);
    chk("rst_ov", {127'h0, bus.out_valid}, 128'h0);
    chk("rst_busy", {127'h0, bus.busy}, 128'h0);
    chk("rst_round", {124'h0, bus.round_idx}, 128'h0);
    chk("rst_data", bus.out_data, 128'h0);
    chk("rst_key", bus.out_key, 128'h0);
    chk("rst_rcon", {120'h0, dut.rcon_q}, 128'h01);
    rst_n = 1'b1;
    #1 chk("rel_ir", {127'h0, bus.in_ready}, 128'h1);

    // FIPS-197 C.1 and App. B with out_ready high
    bus.out_ready = 1'b1;
    drive(C1_PT, C1_KEY);
    track("c1", C1_CT, C1_RK, 1'b0);
    idle_chk("c1", C1_CT);
    drive(B_PT, B_KEY);
    track("appb", B_CT, B_RK, 1'b0);
    idle_chk("appb", B_CT);

    // Backpressure with a pending block held on the input
    bus.out_ready = 1'b0;
    drive(C1_PT, C1_KEY);
    track("bp", C1_CT, C1_RK, 1'b0);
    drive(B_PT, B_KEY);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("bp_ov%0d", i), {127'h0, bus.out_valid}, 128'h1);
      chk($sformatf("bp_data%0d", i), bus.out_data, C1_CT);
      chk($sformatf("bp_ir%0d", i), {127'h0, bus.in_ready}, 128'h0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_ov", {127'h0, bus.out_valid}, 128'h0);
    chk("bp_rel_ir", {127'h0, bus.in_ready}, 128'h1);
    track("bp_pend", B_CT, B_RK, 1'b0);
    idle_chk("bp_pend", B_CT);

    // Back-to-back streaming; the second block is offered while DONE
    drive(C1_PT, C1_KEY);
    track("b2b_a", C1_CT, C1_RK, 1'b0);
    drive(B_PT, B_KEY);
    @(negedge clk);
    chk("b2b_ir", {127'h0, bus.in_ready}, 128'h1);
    chk("b2b_ov", {127'h0, bus.out_valid}, 128'h0);
    chk("b2b_rcon", {120'h0, dut.rcon_q}, 128'h01);
    track("b2b_b", B_CT, B_RK, 1'b0);
    idle_chk("b2b_b", B_CT);

    // Reset in round 5
    drive(C1_PT, C1_KEY);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_round5", {124'h0, bus.round_idx}, 128'd5);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_ov", {127'h0, bus.out_valid}, 128'h0);
    chk("mid_rst_busy", {127'h0, bus.busy}, 128'h0);
    chk("mid_rst_round", {124'h0, bus.round_idx}, 128'h0);
    chk("mid_rst_ir", {127'h0, bus.in_ready}, 128'h0);
    chk("mid_rst_data", bus.out_data, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("mid_rel_ir", {127'h0, bus.in_ready}, 128'h1);
    drive(C1_PT, C1_KEY);
    track("post_rst", C1_CT, C1_RK, 1'b0);
    idle_chk("post_rst", C1_CT);

    // Inputs scrambled every cycle after the accept edge
    drive(B_PT, B_KEY);
    track("perturb", B_CT, B_RK, 1'b1);
    idle_chk("perturb", B_CT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
